// File: rtl/score_display_ctrl.sv
// Shares one serial shift-add-3 binary-to-BCD converter between two score requesters
// with round-robin arbitration, and holds the two-digit BCD result for each team.
module score_display_ctrl #(
  parameter int VAL_W   = 7,
  parameter int MAX_VAL = 99
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_a,
  input  logic [VAL_W-1:0] val_a,
  input  logic             req_b,
  input  logic [VAL_W-1:0] val_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             busy,
  output logic [3:0]       a_tens,
  output logic [3:0]       a_ones,
  output logic             tens_show_a,
  output logic [3:0]       b_tens,
  output logic [3:0]       b_ones,
  output logic             tens_show_b
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam logic [VAL_W-1:0] MAX_V    = VAL_W'(MAX_VAL);
  localparam logic [2:0]       LAST_CNT = 3'(VAL_W - 1);

  state_t           state;
  logic [VAL_W-1:0] bin;
  logic [7:0]       bcd;
  logic [2:0]       cnt;
  logic             grantee_b;
  logic             last_b;

  logic             elig_a;
  logic             elig_b;
  logic             grant_a;
  logic [VAL_W-1:0] val_sel;
  logic [VAL_W-1:0] clamped;
  logic [7:0]       adj;

  // A team that has just been acked sits out one cycle, so the other team gets in.
  always_comb begin
    elig_a  = req_a & ~ack_a;
    elig_b  = req_b & ~ack_b;
    grant_a = elig_a & (~elig_b | last_b);
    val_sel = grant_a ? val_a : val_b;
    clamped = (val_sel > MAX_V) ? MAX_V : val_sel;
    adj     = bcd;
    if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bin         <= '0;
      bcd         <= '0;
      cnt         <= '0;
      grantee_b   <= 1'b0;
      last_b      <= 1'b1;
      busy        <= 1'b0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      a_tens      <= '0;
      a_ones      <= '0;
      tens_show_a <= 1'b0;
      b_tens      <= '0;
      b_ones      <= '0;
      tens_show_b <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      case (state)
        IDLE: begin
          if (elig_a | elig_b) begin
            bin       <= clamped;
            bcd       <= '0;
            cnt       <= '0;
            grantee_b <= ~grant_a;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, bin} <= {adj, bin} << 1;
          cnt        <= cnt + 3'd1;
          if (cnt == LAST_CNT) state <= COMMIT;
        end
        COMMIT: begin
          if (grantee_b) begin
            b_tens      <= bcd[7:4];
            b_ones      <= bcd[3:0];
            tens_show_b <= (bcd[7:4] != 4'd0);
            ack_b       <= 1'b1;
          end else begin
            a_tens      <= bcd[7:4];
            a_ones      <= bcd[3:0];
            tens_show_a <= (bcd[7:4] != 4'd0);
            ack_a       <= 1'b1;
          end
          last_b <= grantee_b;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: latency, digits, blanking, arbitration order,
// clamping and reset during a conversion.
module tb_score_display_ctrl;

  logic       clk;
  logic       reset_n;
  logic       req_a;
  logic [6:0] val_a;
  logic       req_b;
  logic [6:0] val_b;
  logic       ack_a;
  logic       ack_b;
  logic       busy;
  logic [3:0] a_tens;
  logic [3:0] a_ones;
  logic       tens_show_a;
  logic [3:0] b_tens;
  logic [3:0] b_ones;
  logic       tens_show_b;

  int checks = 0;
  int errs   = 0;

  int  ackCycle[8];
  byte ackWho[8];
  int  nAcks;
  logic busyAt1;

  score_display_ctrl #(.VAL_W(7), .MAX_VAL(99)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .val_a(val_a), .req_b(req_b), .val_b(val_b),
    .ack_a(ack_a), .ack_b(ack_b), .busy(busy),
    .a_tens(a_tens), .a_ones(a_ones), .tens_show_a(tens_show_a),
    .b_tens(b_tens), .b_ones(b_ones), .tens_show_b(tens_show_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ra, input logic [6:0] va, input logic rb, input logic [6:0] vb);
    @(negedge clk);
    req_a = ra;
    val_a = va;
    req_b = rb;
    val_b = vb;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errs++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Cycle 1 is the capture edge; acks are logged with their cycle index.
  task automatic watchAcks(input int budget, input int wanted, input bit dropOnAck);
    nAcks = 0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) busyAt1 = busy;
      if (ack_a && nAcks < 8) begin
        ackCycle[nAcks] = n; ackWho[nAcks] = "A"; nAcks++;
        if (dropOnAck) req_a = 1'b0;
      end
      if (ack_b && nAcks < 8) begin
        ackCycle[nAcks] = n; ackWho[nAcks] = "B"; nAcks++;
        if (dropOnAck) req_b = 1'b0;
      end
      if (nAcks >= wanted) break;
    end
    if (nAcks < wanted) checkOutput("ack_timeout", nAcks, wanted);
  endtask

  initial begin
    reset_n = 1'b0;
    req_a = 1'b0; val_a = '0; req_b = 1'b0; val_b = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_a_tens", a_tens, 0);
    checkOutput("rst_a_ones", a_ones, 0);
    checkOutput("rst_show_a", tens_show_a, 0);
    checkOutput("rst_b_tens", b_tens, 0);
    checkOutput("rst_b_ones", b_ones, 0);
    checkOutput("rst_show_b", tens_show_b, 0);
    checkOutput("rst_acks", {ack_a, ack_b}, 0);
    checkOutput("rst_busy", busy, 0);
    @(negedge clk) reset_n = 1'b1;

    $display("[TB] team A 42");
    applyStimulus(1'b1, 7'd42, 1'b0, 7'd0);
    watchAcks(40, 1, 1'b1);
    checkOutput("a42_busy", busyAt1, 1);
    checkOutput("a42_latency", ackCycle[0] - 1, 8);
    checkOutput("a42_tens", a_tens, 4);
    checkOutput("a42_ones", a_ones, 2);
    checkOutput("a42_show", tens_show_a, 1);
    checkOutput("a42_b_digits", {b_tens, b_ones, 3'b000, tens_show_b}, 0);
    @(posedge clk); #1;
    checkOutput("a42_ack_width", ack_a, 0);
    checkOutput("a42_idle_busy", busy, 0);

    $display("[TB] team B 7");
    applyStimulus(1'b0, 7'd0, 1'b1, 7'd7);
    watchAcks(40, 1, 1'b1);
    checkOutput("b7_who", ackWho[0], "B");
    checkOutput("b7_tens", b_tens, 0);
    checkOutput("b7_ones", b_ones, 7);
    checkOutput("b7_show", tens_show_b, 0);
    checkOutput("b7_a_digits", {a_tens, a_ones}, 8'h42);

    $display("[TB] simultaneous requests after reset");
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    applyStimulus(1'b1, 7'd15, 1'b1, 7'd99);
    @(posedge clk);
    @(negedge clk) val_a = 7'd3;
    nAcks = 0;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ack_a && nAcks < 8) begin ackCycle[nAcks] = n; ackWho[nAcks] = "A"; nAcks++; req_a = 1'b0; end
      if (ack_b && nAcks < 8) begin ackCycle[nAcks] = n; ackWho[nAcks] = "B"; nAcks++; req_b = 1'b0; end
      if (nAcks >= 2) break;
    end
    checkOutput("tie_ack_count", nAcks, 2);
    checkOutput("tie_first", ackWho[0], "A");
    checkOutput("tie_ack_a_lat", ackCycle[0] - 1, 8);
    checkOutput("tie_second", ackWho[1], "B");
    checkOutput("tie_ack_b_lat", ackCycle[1] - 1, 17);
    checkOutput("tie_a_digits", {a_tens, a_ones}, 8'h15);
    checkOutput("tie_b_digits", {b_tens, b_ones}, 8'h99);

    $display("[TB] clamp and alternation");
    applyStimulus(1'b1, 7'd120, 1'b1, 7'd63);
    watchAcks(80, 4, 1'b0);
    checkOutput("alt_0", ackWho[0], "A");
    checkOutput("alt_1", ackWho[1], "B");
    checkOutput("alt_2", ackWho[2], "A");
    checkOutput("alt_3", ackWho[3], "B");
    checkOutput("alt_period", ackCycle[1] - ackCycle[0], 9);
    checkOutput("clamp_a_digits", {a_tens, a_ones}, 8'h99);
    checkOutput("clamp_b_digits", {b_tens, b_ones}, 8'h63);
    applyStimulus(1'b0, 7'd0, 1'b0, 7'd0);
    repeat (12) @(posedge clk);

    $display("[TB] reset during conversion");
    applyStimulus(1'b1, 7'd30, 1'b0, 7'd0);
    repeat (4) @(posedge clk);
    @(negedge clk) reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_a_digits", {a_tens, a_ones}, 0);
    checkOutput("midrst_b_digits", {b_tens, b_ones}, 0);
    checkOutput("midrst_acks", {ack_a, ack_b}, 0);
    @(negedge clk) reset_n = 1'b1;
    watchAcks(40, 1, 1'b1);
    checkOutput("restart_who", ackWho[0], "A");
    checkOutput("restart_latency", ackCycle[0] - 1, 8);
    checkOutput("restart_a_digits", {a_tens, a_ones}, 8'h30);
    checkOutput("restart_show_a", tens_show_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
